// File: rtl/inst_decode_queue_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for inst_decode_queue.
// master = fetch/execute side, slave = the decode queue itself.
interface inst_decode_queue_if;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [3:0]  out_opcode;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs;
  logic [3:0]  out_rt;
  logic [15:0] out_imm;
  logic        out_is_branch;
  logic        out_is_load;
  logic        out_is_store;
  logic        out_is_halt;
  logic        out_illegal;
  logic        halted;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode,
    input  out_rd, out_rs, out_rt, out_imm,
    input  out_is_branch, out_is_load, out_is_store,
    input  out_is_halt, out_illegal, halted
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode,
    output out_rd, out_rs, out_rt, out_imm,
    output out_is_branch, out_is_load, out_is_store,
    output out_is_halt, out_illegal, halted
  );
endinterface

// File: rtl/inst_decode_queue.sv
// Decode stage: {instr,pc} FIFO feeding a registered decoded output.
// Optional DECODE_ILLEGAL_TRAP_EN: opcode 0xE flags illegal and traps.
module inst_decode_queue #(
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  inst_decode_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] HALTED = 2'd1;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic [1:0] TRAP   = 2'd2;
`endif

  logic [1:0]    state;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc [DEPTH];
  logic          run;
  logic          push;
  logic          load;
  logic          xfer;
  logic          stop;
  logic [15:0]   head;
  logic          d_br;
  logic          d_ld;
  logic          d_st;
  logic          d_halt;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic          d_ill;
`endif

  assign run  = state == RUN;
  assign bus.in_ready = !rst && run && !bus.flush
                        && count < FULL;
  assign push = bus.in_valid && bus.in_ready;
  assign xfer = run && bus.out_valid && bus.out_ready;
  assign stop = xfer
                && (bus.out_is_halt || bus.out_illegal);
  assign load = run && !bus.flush && !stop
                && count != '0
                && (!bus.out_valid || bus.out_ready);
  assign head = mem_instr[rd_ptr];
  assign bus.halted = !run;

  always_comb begin
    d_br   = 1'b0;
    d_ld   = 1'b0;
    d_st   = 1'b0;
    d_halt = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    d_ill  = 1'b0;
`endif
    case (head[15:12])
      4'h9:       d_ld   = 1'b1;
      4'hA:       d_st   = 1'b1;
      4'hB, 4'hC: d_br   = 1'b1;
      4'hF:       d_halt = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
      4'hE:       d_ill  = 1'b1;
`endif
      default:    ;
    endcase
  end

  // Storage needs no reset: count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= bus.in_instr;
      mem_pc[wr_ptr]    <= bus.in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      bus.out_valid <= 1'b0;
    end else if (run) begin
      if (bus.flush) begin
        count         <= '0;
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        bus.out_valid <= 1'b0;
      end else if (stop) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        state         <= bus.out_illegal ? TRAP : HALTED;
`else
        state         <= HALTED;
`endif
        count         <= '0;
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        bus.out_valid <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (load) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, push}
                       - {{AW{1'b0}}, load};
        if (load)
          bus.out_valid <= 1'b1;
        else if (xfer)
          bus.out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_pc        <= '0;
      bus.out_opcode    <= '0;
      bus.out_rd        <= '0;
      bus.out_rs        <= '0;
      bus.out_rt        <= '0;
      bus.out_imm       <= '0;
      bus.out_is_branch <= 1'b0;
      bus.out_is_load   <= 1'b0;
      bus.out_is_store  <= 1'b0;
      bus.out_is_halt   <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      bus.out_illegal   <= 1'b0;
`endif
    end else if (load) begin
      bus.out_pc        <= mem_pc[rd_ptr];
      bus.out_opcode    <= head[15:12];
      bus.out_rd        <= head[11:8];
      bus.out_rs        <= head[7:4];
      bus.out_rt        <= head[3:0];
      bus.out_imm       <= {{8{head[7]}}, head[7:0]};
      bus.out_is_branch <= d_br;
      bus.out_is_load   <= d_ld;
      bus.out_is_store  <= d_st;
      bus.out_is_halt   <= d_halt;
`ifdef DECODE_ILLEGAL_TRAP_EN
      bus.out_illegal   <= d_ill;
`endif
    end
  end

`ifndef DECODE_ILLEGAL_TRAP_EN
  assign bus.out_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_inst_decode_queue.sv
// Randomized self-checking bench for inst_decode_queue.
// Model tracks buffered stream order, occupancy and halt status.
module tb_inst_decode_queue;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  inst_decode_queue_if bus ();

  inst_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: q holds every accepted-but-not-consumed item,
  // front first; m_pres says the front is on the output.
  logic [47:0] q[$];
  int          m_qlen;
  bit          m_pres;
  bit          m_halted;

  function automatic bit is_stop(logic [15:0] i);
`ifdef DECODE_ILLEGAL_TRAP_EN
    return i[15:12] == 4'hF || i[15:12] == 4'hE;
`else
    return i[15:12] == 4'hF;
`endif
  endfunction

  function automatic logic [68:0] exp_fields(logic [47:0] it);
    logic [15:0] i;
    logic [3:0]  op;
    logic        il;
    i  = it[15:0];
    op = i[15:12];
`ifdef DECODE_ILLEGAL_TRAP_EN
    il = op == 4'hE;
`else
    il = 1'b0;
`endif
    return {it[47:16], op, i[11:8], i[7:4], i[3:0],
            16'($signed(i[7:0])),
            op == 4'hB || op == 4'hC, op == 4'h9,
            op == 4'hA, op == 4'hF, il};
  endfunction

  function automatic logic [68:0] got_fields();
    return {bus.out_pc, bus.out_opcode, bus.out_rd,
            bus.out_rs, bus.out_rt, bus.out_imm,
            bus.out_is_branch, bus.out_is_load,
            bus.out_is_store, bus.out_is_halt,
            bus.out_illegal};
  endfunction

  function automatic bit exp_in_ready();
    return !rst && !m_halted && !bus.flush
           && m_qlen < DEPTH;
  endfunction

  task automatic model_reset();
    q.delete();
    m_qlen   = 0;
    m_pres   = 0;
    m_halted = 0;
  endtask

  task automatic drive(bit v, logic [15:0] i,
                       logic [31:0] p);
    bus.in_valid = v;
    bus.in_instr = i;
    bus.in_pc    = p;
  endtask

  // Advance one clock and apply the stage rules to the model.
  task automatic tick();
    bit xf;
    bit ld;
    bit pu;
    @(posedge clk);
    if (!m_halted) begin
      if (bus.flush) begin
        q.delete();
        m_qlen = 0;
        m_pres = 0;
      end else begin
        xf = m_pres && bus.out_ready;
        if (xf && is_stop(q[0][15:0])) begin
          m_halted = 1;
          q.delete();
          m_qlen = 0;
          m_pres = 0;
        end else begin
          ld = m_qlen > 0 && (!m_pres || bus.out_ready);
          pu = bus.in_valid && m_qlen < DEPTH;
          if (xf) void'(q.pop_front());
          if (pu) q.push_back({bus.in_pc, bus.in_instr});
          m_qlen = m_qlen - int'(ld) + int'(pu);
          m_pres = ld ? 1'b1 : (xf ? 1'b0 : m_pres);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 16'h0, 32'h0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] i;
    i = 16'($urandom);
    i[15:12] = 4'($urandom_range(0, 13));
    return i;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 16'h1234, 32'h10);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b exp=0",
               bus.in_ready);
    end
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0
        || got_fields() !== 69'b0) begin
      n_fail++;
      $display("FAIL reset_outputs valid=%b halted=%b f=%h exp=0",
               bus.out_valid, bus.halted, got_fields());
    end
    drive(0, 16'h0, 32'h0);
    bus.out_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_in_ready got=%b exp=1",
               bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    drive(1, 16'h1123, 32'd0);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency got=%b exp=0",
               bus.out_valid);
    end
    drive(1, 16'h8A05, 32'd1);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_opcode !== 4'd1
        || bus.out_rd !== 4'd1 || bus.out_rs !== 4'd2
        || bus.out_rt !== 4'd3 || bus.out_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL basic_add v=%b op=%h rd=%h rs=%h rt=%h pc=%h exp=1/1/1/2/3/0",
               bus.out_valid, bus.out_opcode, bus.out_rd,
               bus.out_rs, bus.out_rt, bus.out_pc);
    end
    drive(1, 16'h80FF, 32'd2);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_opcode !== 4'd8
        || bus.out_rd !== 4'd10 || bus.out_imm !== 16'h0005
        || bus.out_pc !== 32'd1) begin
      n_fail++;
      $display("FAIL basic_addi op=%h rd=%h imm=%h pc=%h exp=8/a/0005/1",
               bus.out_opcode, bus.out_rd, bus.out_imm,
               bus.out_pc);
    end
    drive(0, 16'h0, 32'h0);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_imm !== 16'hFFFF
        || bus.out_pc !== 32'd2) begin
      n_fail++;
      $display("FAIL basic_signext v=%b imm=%h pc=%h exp=1/ffff/2",
               bus.out_valid, bus.out_imm, bus.out_pc);
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain got=%b exp=0",
               bus.out_valid);
    end
  endtask

  task automatic test_full();
    logic [47:0] items[5];
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      items[k] = {32'h100 + 32'(k), rand_instr()};
      drive(1, items[k][15:0], items[k][47:16]);
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL full_accept_%0d got=%b exp=1",
                 k, bus.in_ready);
      end
      tick();
    end
    drive(1, 16'h7777, 32'h999);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_in_ready got=%b exp=0",
               bus.in_ready);
    end
    tick();
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_pushthrough got=%b exp=0",
               bus.in_ready);
    end
    drive(0, 16'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1
          || got_fields() !== exp_fields(items[k])) begin
        n_fail++;
        $display("FAIL full_order_%0d v=%b got=%h exp=%h",
                 k, bus.out_valid, got_fields(),
                 exp_fields(items[k]));
      end
      tick();
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty got=%b exp=0",
               bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, rand_instr(), 32'h200 + 32'(k));
      tick();
    end
    bus.flush = 1'b1;
    drive(1, 16'h1234, 32'h300);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_ready got=%b exp=0",
               bus.in_ready);
    end
    tick();
    bus.flush = 1'b0;
    drive(0, 16'h0, 32'h0);
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear v=%b rdy=%b exp=0/1",
               bus.out_valid, bus.in_ready);
    end
    repeat (3) tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_lost got=%b exp=0",
               bus.out_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 39) == 0);
      drive(($urandom_range(0, 9) < 7), rand_instr(),
            $urandom);
      #1;
      n_tests++;
      if (bus.in_ready !== exp_in_ready()) begin
        n_fail++;
        $display("FAIL rand_in_ready c=%0d got=%b exp=%b",
                 c, bus.in_ready, exp_in_ready());
      end
      tick();
      n_tests++;
      if (bus.out_valid !== m_pres) begin
        n_fail++;
        $display("FAIL rand_valid c=%0d got=%b exp=%b",
                 c, bus.out_valid, m_pres);
      end else if (m_pres) begin
        n_tests++;
        if (got_fields() !== exp_fields(q[0])) begin
          n_fail++;
          $display("FAIL rand_fields c=%0d got=%h exp=%h",
                   c, got_fields(), exp_fields(q[0]));
        end
      end
    end
    bus.flush = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, rand_instr(), 32'h400 + 32'(k));
      tick();
    end
    drive(0, 16'h0, 32'h0);
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0
        || got_fields() !== 69'b0) begin
      n_fail++;
      $display("FAIL async_reset v=%b rdy=%b f=%h exp=0",
               bus.out_valid, bus.in_ready, got_fields());
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.out_ready = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_empty got=%b exp=0",
               bus.out_valid);
    end
  endtask

  task automatic test_halt();
    do_reset();
    bus.out_ready = 1'b1;
    drive(1, 16'hF000, 32'h40);
    tick();
    drive(1, 16'h1111, 32'h41);
    tick();
    drive(0, 16'h0, 32'h0);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_is_halt !== 1'b1
        || bus.out_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL halt_present v=%b h=%b pc=%h exp=1/1/40",
               bus.out_valid, bus.out_is_halt, bus.out_pc);
    end
    tick();
    n_tests++;
    if (bus.halted !== 1'b1 || bus.in_ready !== 1'b0
        || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_enter h=%b rdy=%b v=%b exp=1/0/0",
               bus.halted, bus.in_ready, bus.out_valid);
    end
    for (int k = 0; k < 6; k++) begin
      drive(1, rand_instr(), 32'h500 + 32'(k));
      bus.flush = k[0];
      tick();
    end
    bus.flush = 1'b0;
    n_tests++;
    if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0
        || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_sticky h=%b v=%b rdy=%b exp=1/0/0",
               bus.halted, bus.out_valid, bus.in_ready);
    end
    do_reset();
    #1;
    n_tests++;
    if (bus.halted !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_exit h=%b rdy=%b exp=0/1",
               bus.halted, bus.in_ready);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    bus.out_ready = 1'b1;
    drive(1, 16'hE123, 32'h80);
    tick();
    drive(1, 16'h1234, 32'h81);
    tick();
    drive(0, 16'h0, 32'h0);
    n_tests++;
    if (bus.out_valid !== 1'b1
        || got_fields() !== exp_fields({32'h80, 16'hE123})) begin
      n_fail++;
      $display("FAIL illegal_present v=%b got=%h exp=%h",
               bus.out_valid, got_fields(),
               exp_fields({32'h80, 16'hE123}));
    end
    tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
    n_tests++;
    if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0
        || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_trap h=%b v=%b rdy=%b exp=1/0/0",
               bus.halted, bus.out_valid, bus.in_ready);
    end
`else
    n_tests++;
    if (bus.halted !== 1'b0 || bus.out_valid !== 1'b1
        || bus.out_pc !== 32'h81 || bus.out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_nop h=%b v=%b pc=%h il=%b exp=0/1/81/0",
               bus.halted, bus.out_valid, bus.out_pc,
               bus.out_illegal);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 16'h0, 32'h0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_random();
    test_async_reset();
    test_halt();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
